id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32: datapath width.
REQ-002 Clk  input  1  rising-edge clock; the block SHALL use this single clock.
REQ-003 Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Stall  input  1  global freeze (memory wait); all EX state holds.
REQ-005 Flush  input  1  squash (taken branch); the next EX entry is a bubble.
REQ-006 IdValid  input  1  ID holds a real instruction.
REQ-007 IdCtrl  input  8  control bundle: [1:0] AluOp, [2] AluSrc, [3] RegDst, [4] MemRead, [5] MemWrite, [6] MemToReg, [7] RegWrite.
REQ-008 IdFunc  input  6  instruction funct field.
REQ-009 IdRs, IdRt, IdRd  input  5 each  register specifiers.
REQ-010 IdReadData1, IdReadData2  input  DATA_W  register-file read data.
REQ-011 IdImm  input  DATA_W  sign-extended immediate.
REQ-012 ExValid  output  1  EX holds a real instruction.
REQ-013 ExCtrl  output  8  registered control bundle.
REQ-014 ExAluOp  output  2  equals ExCtrl[1:0]; feeds ALU control.
REQ-015 ExFunc  output  6  registered funct; feeds ALU control.
REQ-016 ExReadData1, ExReadData2, ExImm  output  DATA_W  registered operands.
REQ-017 ExRs, ExRt, ExWriteReg  output  5 each; ExWriteReg is IdRd if RegDst=1, else IdRt, selected at load.
REQ-018 HazardStall  output  1  combinational load-use stall request to PC and IF/ID.
REQ-019 BubbleCount  output  16  saturating count of inserted bubbles.

Function
REQ-020 HazardStall SHALL be 1 only when ExValid, ExCtrl[4], ExRt!=0 and IdValid are all true and ExRt equals IdRs or IdRt. It has zero-cycle latency and no registers.
REQ-021 Each rising Clk edge SHALL apply the first matching case, in priority order Flush > Stall > HazardStall > normal load.
- Flush: load a bubble.
- Stall (no Flush): hold all EX registers and BubbleCount.
- HazardStall: load a bubble.
- Otherwise: load all Id* fields and set ExValid=IdValid.
REQ-022 A bubble SHALL set ExValid=0 and zero every other EX register: ExCtrl, ExFunc, data, ExRs, ExRt, ExWriteReg.
REQ-023 Loading with IdValid=0 SHALL force ExCtrl=0 regardless of IdCtrl, so an invalid instruction never writes a register or memory.
REQ-024 ID->EX latency SHALL be exactly one cycle.
REQ-025 BubbleCount SHALL increment by 1 on each edge that loads a bubble (Flush or hazard) and saturate at 16'hFFFF.
REQ-026 A load-use hazard SHALL cost exactly one bubble: after the bubble, the EX entry is no longer a load, so HazardStall drops with no extra logic.
REQ-027 A load whose Rt is 0 SHALL never raise HazardStall.

Reset
REQ-028 While Rst_n=0, all EX registers, ExValid and BubbleCount SHALL clear to 0 immediately, without waiting for a clock edge; HazardStall is therefore 0.
REQ-029 Reset asserted mid-Stall or mid-hazard SHALL discard the held instruction.
REQ-030 The first rising edge after reset release SHALL perform a normal REQ-021 evaluation.

Structure
REQ-031 Shared package pipe_pkg SHALL hold CTRL_W=8, REG_W=5 and the IdCtrl bit-index constants (ALUOP_LO, ALUSRC, REGDST, MEMREAD, MEMWRITE, MEMTOREG, REGWRITE).
REQ-032 The combinational load-use compare SHALL be a sub-module hazard_detect, instantiated once.
REQ-033 All state SHALL reside in one clocked process sensitive to the rising edge of Clk and the falling edge of Rst_n.

Verification
REQ-034 Reset: drive Rst_n=0 between clock edges while a valid instruction is loaded -> all outputs 0 before the next edge.
REQ-035 Pass-through: IdValid=1, IdCtrl=8'b1000_1010, IdFunc=6'h20, IdRd=3 -> after one edge: ExValid=1, ExAluOp=2'b10, ExFunc=6'h20, ExWriteReg=3.
REQ-036 Load-use: EX holds a lw (ExCtrl[4]=1, ExRt=5) and ID holds an add with IdRs=5 -> HazardStall=1 in the same cycle; after the edge: ExValid=0, ExCtrl=0, BubbleCount=1, HazardStall=0.
REQ-037 Zero register: EX holds a lw with ExRt=0 and ID has IdRs=0 -> HazardStall=0 and the instruction loads normally.
REQ-038 Priority: Stall=1 for 3 cycles -> EX outputs unchanged; Stall=1 and Flush=1 on the same edge -> bubble loaded and BubbleCount increments.
REQ-039 Saturation: 65540 consecutive Flush edges -> BubbleCount=16'hFFFF and no wrap to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: control bundle layout and register-specifier width.
package pipe_pkg;

    localparam int CTRL_W = 8;
    localparam int REG_W  = 5;
    localparam int FUNC_W = 6;
    localparam int CNT_W  = 16;

    // Bit positions inside the ID/EX control bundle
    localparam int ALUOP_LO = 0;
    localparam int ALUOP_HI = 1;
    localparam int ALUSRC   = 2;
    localparam int REGDST   = 3;
    localparam int MEMREAD  = 4;
    localparam int MEMWRITE = 5;
    localparam int MEMTOREG = 6;
    localparam int REGWRITE = 7;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating increment for the bubble counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction sitting in ID. Purely combinational.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hazard
);

    // Register 0 is hard-wired, so a load targeting it never creates a dependency
    always_comb begin
        hazard = ex_valid && ex_mem_read && (ex_rt != '0) && id_valid &&
                 ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, freeze, load-use bubble insertion and a
// saturating bubble counter.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [FUNC_W-1:0] id_func,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_read_data1,
    input  logic [DATA_W-1:0] id_read_data2,
    input  logic [DATA_W-1:0] id_imm,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [1:0]        ex_alu_op,
    output logic [FUNC_W-1:0] ex_func,
    output logic [DATA_W-1:0] ex_read_data1,
    output logic [DATA_W-1:0] ex_read_data2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_write_reg,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_count
);

    logic load_bubble;
    logic update;

    hazard_detect u_hazard_detect (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl[MEMREAD]),
        .ex_rt       (ex_rt),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .hazard      (hazard_stall)
    );

    assign ex_alu_op = ex_ctrl[ALUOP_HI:ALUOP_LO];

    // Flush beats stall; a hazard only inserts a bubble when the pipe is not frozen
    always_comb begin
        update      = flush || !stall;
        load_bubble = flush || (!stall && hazard_stall);
    end

    // All EX state and the bubble counter; reset discards any held instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_ctrl       <= '0;
            ex_func       <= '0;
            ex_read_data1 <= '0;
            ex_read_data2 <= '0;
            ex_imm        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_write_reg  <= '0;
            bubble_count  <= '0;
        end else if (update) begin
            if (load_bubble) begin
                ex_valid      <= 1'b0;
                ex_ctrl       <= '0;
                ex_func       <= '0;
                ex_read_data1 <= '0;
                ex_read_data2 <= '0;
                ex_imm        <= '0;
                ex_rs         <= '0;
                ex_rt         <= '0;
                ex_write_reg  <= '0;
                bubble_count  <= sat_inc(bubble_count);
            end else begin
                ex_valid      <= id_valid;
                // An invalid slot must never carry write enables forward
                ex_ctrl       <= id_valid ? id_ctrl : '0;
                ex_func       <= id_func;
                ex_read_data1 <= id_read_data1;
                ex_read_data2 <= id_read_data2;
                ex_imm        <= id_imm;
                ex_rs         <= id_rs;
                ex_rt         <= id_rt;
                ex_write_reg  <= id_ctrl[REGDST] ? id_rd : id_rt;
            end
        end
    end

endmodule
